// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, divider state encoding, widths.
// Imported by the divider, its step slice and its bus interface.
package alu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_RL  = 4'b1011;
    localparam logic [3:0] OP_RR  = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Divider request/result bundle between control unit and seq_divider.
// master: start, A, B out; results in.  slave: the divider side.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] outputLOW;
    logic [WIDTH-1:0] outputHI;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, A, B,
        input  outputLOW, outputHI, busy, done, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output outputLOW, outputHI, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step (combinational).
// rem_i/msb_i/dsr_i in; rem_o (next remainder), q_o (quotient bit) out.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem_i, msb_i};
        trial   = shifted - {2'b00, dsr_i};
        // Top bit of the widened trial is its sign.
        q_o     = ~trial[WIDTH+1];
        rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: LO = quotient, HI = remainder.
// Ports: clk, clr (sync high reset), bus (seq_divider_if.slave).
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic           clk,
    input  logic           clr,
    seq_divider_if.slave   bus
);
    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[WIDTH-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    dz_d    = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                sgn_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                sgn_r_d = a_q[WIDTH-1];
                // -2^(W-1) negates to itself, which is its magnitude unsigned.
                dvd_d   = a_q[WIDTH-1] ? -a_q : a_q;
                dsr_d   = b_q[WIDTH-1] ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH);
                if (b_q == '0) begin
                    lo_d    = '1;
                    hi_d    = a_q;
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // Dividend bits shift out the top as quotient bits enter below.
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                lo_d    = sgn_q_q ? -dvd_q : dvd_q;
                hi_d    = sgn_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
        end
    end

    // Status comes straight from the state register.
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.outputLOW   = lo_q;
    assign bus.outputHI    = hi_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signed cases, div-by-zero,
// ignored start while busy, mid-operation clear.
module tb_seq_divider;
    logic clk;
    logic clr;
    int   n_chk;
    int   n_err;

    seq_divider_if #(.WIDTH(32)) dif ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .clr (clr),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide and follow it to done. n counts cycles with the
    // accepting edge's following cycle as 1. inj: cycle at which a
    // second (ignored) start with 9/2 is pulsed; 0 = none.
    task automatic run_div(input string tag,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int lat, input int inj);
        int n;
        @(negedge clk);
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.A     = ~a;
        dif.B     = 32'd5;
        n = 1;
        check({tag, " busy"}, {31'd0, dif.busy}, 32'd1);
        check({tag, " dz_clr"}, {31'd0, dif.div_by_zero}, 32'd0);
        while (!dif.done && n < 60) begin
            if (n == inj) begin
                dif.start = 1'b1;
                dif.A     = 32'd9;
                dif.B     = 32'd2;
            end
            @(posedge clk);
            #1;
            dif.start = 1'b0;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " q"}, dif.outputLOW, eq);
        check({tag, " r"}, dif.outputHI, er);
        check({tag, " dz"}, {31'd0, dif.div_by_zero}, {31'd0, edz});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, dif.done}, 32'd0);
        check({tag, " idle"}, {31'd0, dif.busy}, 32'd0);
        check({tag, " q_hold"}, dif.outputLOW, eq);
    endtask

    initial begin
        int n;
        int seen;
        n_chk     = 0;
        n_err     = 0;
        clr       = 1'b1;
        dif.start = 1'b0;
        dif.A     = '0;
        dif.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst lo", dif.outputLOW, 32'd0);
        check("rst hi", dif.outputHI, 32'd0);
        check("rst busy", {31'd0, dif.busy}, 32'd0);
        check("rst done", {31'd0, dif.done}, 32'd0);
        check("rst dz", {31'd0, dif.div_by_zero}, 32'd0);

        run_div("p/p", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 0);
        run_div("n/p", -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE,
                1'b0, 35, 0);
        run_div("p/n", 32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2,
                1'b0, 35, 0);
        run_div("n/n", -32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE,
                1'b0, 35, 0);
        run_div("min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                32'd0, 1'b0, 35, 0);
        run_div("min/1", 32'h80000000, 32'd1, 32'h80000000, 32'd0,
                1'b0, 35, 0);
        run_div("big", 32'h7FFFFFFF, 32'h00010000, 32'h00007FFF,
                32'h0000FFFF, 1'b0, 35, 0);
        run_div("div0", 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234,
                1'b1, 2, 0);
        run_div("after0", 32'd1234, 32'd3, 32'd411, 32'd1, 1'b0, 35, 0);
        run_div("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 10);

        // Clear in the middle of a divide: everything returns to reset.
        @(negedge clk);
        dif.A     = 32'd100;
        dif.B     = 32'd7;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        n = 1;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr busy", {31'd0, dif.busy}, 32'd0);
        check("clr done", {31'd0, dif.done}, 32'd0);
        check("clr lo", dif.outputLOW, 32'd0);
        check("clr hi", dif.outputHI, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dif.done || dif.busy)
                seen++;
        end
        check("clr no_done", seen, 32'd0);

        run_div("50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 35, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit divider. Sits beside the combinational ALU at the Z-register input and produces the 64-bit {HI, LO} result for the DIV opcode (4'b0011).
- LO carries the quotient and HI the remainder, so the Z stage captures divide results exactly as it captures MUL results.
- A start/busy/done handshake lets the control unit stall its T-state sequence until the result is valid.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  signed dividend; sampled when start is accepted.
- B  input  WIDTH  signed divisor; sampled when start is accepted.
- outputLOW  output  WIDTH  quotient.
- outputHI  output  WIDTH  remainder.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results are valid in that cycle and held afterwards.
- div_by_zero  output  1  set with done when B==0; held until the next accepted start.

Behaviour:
- Reset and clock: one clock, clk. Reset clr is synchronous and active-high.
- Reset values (clr high at a clock edge):
  - outputLOW=0, outputHI=0, done=0, busy=0, div_by_zero=0.
  - State=IDLE, counter=0.
  - clr asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, INIT, ITER, FIX, DONE.
- IDLE:
  - start=1 latches A and B, clears div_by_zero, and moves to INIT.
  - start=0 stays in IDLE.
- INIT:
  - Records sign_q = A[31]^B[31] and sign_r = A[31].
  - Loads |A| and |B| as unsigned 32-bit values; |−2^31| = 0x80000000 unsigned.
  - Clears the 33-bit partial remainder and sets counter=WIDTH.
  - If B==0: outputLOW=32'hFFFFFFFF, outputHI=A, div_by_zero=1, go to DONE.
  - Otherwise go to ITER.
- ITER (restoring algorithm, one quotient bit per cycle):
  - Shift {rem, dvd} left by 1.
  - Trial = rem − |B|. If trial is non-negative, rem=trial and the new quotient LSB=1; else quotient LSB=0.
  - Decrement counter. Exit to FIX after exactly WIDTH iterations.
- FIX:
  - Quotient is negated if sign_q; remainder is negated if sign_r.
  - Result: truncation toward zero; remainder takes the dividend's sign; A == q*B + r always holds.
  - −2^31 / −1 wraps to q=32'h80000000, r=0. No overflow flag.
  - Write outputLOW and outputHI, then go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. Next start is accepted in the following cycle at the earliest.
- Latency, counted from the edge that accepts start:
  - Normal divide: done is high 35 cycles later (INIT 1 + ITER 32 + FIX 1 + DONE 1).
  - Divide by zero: done is high 2 cycles later.
- start while busy is ignored: no queueing, and operands are not re-sampled. A/B changes after acceptance have no effect.
- outputLOW and outputHI hold the last written result until the next FIX or divide-by-zero write. They are never cleared by start alone.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (ADD…RR, DIV=4'b0011).
  - Divider state encoding: IDLE=0, INIT=1, ITER=2, FIX=3, DONE=4; 3-bit.
  - WIDTH default.
- Sub-module div_step: combinational single restoring step.
  - Inputs: 33-bit remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside seq_divider; it is separately unit-testable.

Test Plan:
- A=100, B=7, start pulse → busy=1 next cycle; done exactly 35 cycles after accept; outputLOW=14, outputHI=2, div_by_zero=0.
- A=−100, B=7 → outputLOW=−14 (32'hFFFFFFF2), outputHI=−2 (32'hFFFFFFFE); A=100, B=−7 → q=−14, r=2; A=−100, B=−7 → q=14, r=−2.
- A=32'h80000000, B=32'hFFFFFFFF → q=32'h80000000, r=0, done at 35 cycles; A=32'h80000000, B=1 → q=32'h80000000, r=0.
- A=1234, B=0 → done 2 cycles after accept; div_by_zero=1, outputLOW=32'hFFFFFFFF, outputHI=1234. Next start with B=3 clears div_by_zero on accept.
- Pulse start again at cycle 10 of 100/7 with A=9, B=2 → ignored; result still 14/2 at cycle 35. A start in the cycle after done is accepted.
- clr high at cycle 20 of a divide → the next cycle shows busy=0, done=0, outputs=0, IDLE; no done pulse appears. A fresh 50/5 then yields q=10, r=0.
